lcd_ctrl: RTL

Timing-engine controller for the HD44780-compatible character LCD on the board, sitting downstream of the core's load/store unit. It replaces software bit-banging of the LCD pins. The LSU issues one byte-write strobe per character or command. `lcd_ctrl` then sequences the RS/RW/DATA setup, the EN pulse, the hold time and the controller execution wait. It reports `o_busy` so firmware can poll it through the LCD register. An optional power-up initialisation sequence runs automatically out of reset.

---
 rtl/lcd_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/lcd_ctrl.sv
// HD44780 timing engine: sequences RS/DATA setup, EN pulse, hold and execution wait per LSU byte write.
// Optional power-up init sequence is compiled in with `define LCD_INIT_EN.
module lcd_ctrl #(
   parameter int T_POWERUP = 750000,
   parameter int T_SETUP   = 4,
   parameter int T_PW      = 25,
   parameter int T_HOLD    = 4,
   parameter int T_EXEC    = 2000,
   parameter int T_CLEAR   = 82000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_wr,
   input  logic       i_rs,
   input  logic [7:0] i_data,
   output logic       o_busy,
   output logic       o_drop,
   output logic       o_lcd_on,
   output logic       o_lcd_en,
   output logic       o_lcd_rs,
   output logic       o_lcd_rw,
   output logic [7:0] o_lcd_data
);

   localparam int CNT_MAX = 16777216;

   if (T_POWERUP < 1 || T_POWERUP > CNT_MAX || T_SETUP < 1 || T_SETUP > CNT_MAX ||
       T_PW < 1 || T_PW > CNT_MAX || T_HOLD < 1 || T_HOLD > CNT_MAX ||
       T_EXEC < 1 || T_EXEC > CNT_MAX || T_CLEAR < 1 || T_CLEAR > CNT_MAX) begin : g_bad_param
      $error("lcd_ctrl: timing parameter outside 1..2^24");
   end

   // Counter reload values: a state lasting N cycles is entered with N-1.
   localparam logic [23:0] LD_SETUP = 24'(T_SETUP - 1);
   localparam logic [23:0] LD_PW    = 24'(T_PW - 1);
   localparam logic [23:0] LD_HOLD  = 24'(T_HOLD - 1);
   localparam logic [23:0] LD_EXEC  = 24'(T_EXEC - 1);
   localparam logic [23:0] LD_CLEAR = 24'(T_CLEAR - 1);

`ifdef LCD_INIT_EN
   localparam logic [23:0] LD_PWR = 24'(T_POWERUP - 1);
   typedef enum logic [2:0] {PWR_WAIT, INIT_LOAD, SETUP, PULSE, HOLD, WAIT, IDLE} state_t;
`else
   typedef enum logic [2:0] {SETUP, PULSE, HOLD, WAIT, IDLE} state_t;
`endif

   state_t      state_q, state_d;
   logic [23:0] cnt_q, cnt_d;
   logic        rs_q, rs_d;
   logic [7:0]  data_q, data_d;
   logic        busy_q, busy_d;
   logic        en_q, en_d;
   logic        drop_q, drop_d;
   logic        on_q;
   logic        is_clear;

`ifdef LCD_INIT_EN
   logic [1:0]  idx_q, idx_d;
   logic        init_q, init_d;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    return 8'h38;
         2'd1:    return 8'h0C;
         2'd2:    return 8'h01;
         default: return 8'h06;
      endcase
   endfunction
`endif

   // Clear Display / Return Home need the long execution wait.
   assign is_clear = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rs_d    = rs_q;
      data_d  = data_q;
`ifdef LCD_INIT_EN
      idx_d   = idx_q;
      init_d  = init_q;
`endif
      if (cnt_q != 24'd0) cnt_d = cnt_q - 24'd1;
      case (state_q)
`ifdef LCD_INIT_EN
         PWR_WAIT: if (cnt_q == 24'd0) state_d = INIT_LOAD;
         INIT_LOAD: begin
            rs_d    = 1'b0;
            data_d  = init_cmd(idx_q);
            state_d = SETUP;
            cnt_d   = LD_SETUP;
         end
`endif
         SETUP: if (cnt_q == 24'd0) begin
            state_d = PULSE;
            cnt_d   = LD_PW;
         end
         PULSE: if (cnt_q == 24'd0) begin
            state_d = HOLD;
            cnt_d   = LD_HOLD;
         end
         HOLD: if (cnt_q == 24'd0) begin
            state_d = WAIT;
            cnt_d   = is_clear ? LD_CLEAR : LD_EXEC;
         end
         WAIT: if (cnt_q == 24'd0) begin
            state_d = IDLE;
`ifdef LCD_INIT_EN
            if (init_q) begin
               if (idx_q == 2'd3) begin
                  init_d = 1'b0;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = INIT_LOAD;
               end
            end
`endif
         end
         IDLE: if (i_wr) begin
            rs_d    = i_rs;
            data_d  = i_data;
            state_d = SETUP;
            cnt_d   = LD_SETUP;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
      en_d   = (state_d == PULSE);
      drop_d = i_wr && (state_q != IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
`ifdef LCD_INIT_EN
         state_q <= PWR_WAIT;
         cnt_q   <= LD_PWR;
         busy_q  <= 1'b1;
         idx_q   <= 2'd0;
         init_q  <= 1'b1;
`else
         state_q <= IDLE;
         cnt_q   <= 24'd0;
         busy_q  <= 1'b0;
`endif
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
         en_q    <= 1'b0;
         drop_q  <= 1'b0;
         on_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
`ifdef LCD_INIT_EN
         idx_q   <= idx_d;
         init_q  <= init_d;
`endif
         rs_q    <= rs_d;
         data_q  <= data_d;
         en_q    <= en_d;
         drop_q  <= drop_d;
         on_q    <= 1'b1;
      end
   end

   assign o_busy     = busy_q;
   assign o_drop     = drop_q;
   assign o_lcd_on   = on_q;
   assign o_lcd_en   = en_q;
   assign o_lcd_rs   = rs_q;
   assign o_lcd_rw   = 1'b0;
   assign o_lcd_data = data_q;

endmodule
